// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the MAR/MEM/MDR path between the Fetch and Execute FSMs,
// with an MFC watchdog that ends hung accesses with bus_error.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic fetch_rw,
  output logic fetch_grant,
  output logic fetch_done,
  input  logic exec_req,
  input  logic exec_rw,
  output logic exec_grant,
  output logic exec_done,
  output logic mem_sel,
  output logic MEM_EN,
  output logic MEM_RW,
  input  logic MFC,
  output logic bus_error,
  output logic busy
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        OWN_FETCH = 1'b0;
  localparam logic        OWN_EXEC  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner, w_owner_nxt;
  logic               r_last_owner, w_last_owner_nxt;
  logic               r_rw_q, w_rw_q_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_timeout_q, w_timeout_q_nxt;

  logic w_req_own, w_rw_own;
  logic w_grant_nxt, w_en_nxt, w_done_nxt;

  logic r_fetch_grant, r_fetch_done, r_exec_grant, r_exec_done;
  logic r_mem_sel, r_mem_en, r_mem_rw, r_bus_error, r_busy;

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_FETCH;
      r_last_owner <= OWN_EXEC;
      r_rw_q       <= 1'b1;
      r_cnt        <= '0;
      r_timeout_q  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_rw_q       <= w_rw_q_nxt;
      r_cnt        <= w_cnt_nxt;
      r_timeout_q  <= w_timeout_q_nxt;
    end
  end

  // Next-state logic and output decode of the next state
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_rw_q_nxt       = r_rw_q;
    w_cnt_nxt        = r_cnt;
    w_timeout_q_nxt  = r_timeout_q;
    w_req_own        = (r_owner == OWN_EXEC) ? exec_req : fetch_req;
    w_rw_own         = (r_owner == OWN_EXEC) ? exec_rw  : fetch_rw;

    case (r_state)
      S_IDLE: begin
        if (fetch_req && exec_req) begin
          w_owner_nxt = ~r_last_owner;
          w_state_nxt = S_GRANT;
        end else if (fetch_req) begin
          w_owner_nxt = OWN_FETCH;
          w_state_nxt = S_GRANT;
        end else if (exec_req) begin
          w_owner_nxt = OWN_EXEC;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        // A withdrawn request releases the path without a memory cycle or turn change
        if (!w_req_own) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_rw_q_nxt  = w_rw_own;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_cnt_nxt       = '0;
        w_timeout_q_nxt = 1'b0;
        w_state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        // MFC wins over the watchdog on the final WAIT cycle
        if (MFC) begin
          w_timeout_q_nxt = 1'b0;
          w_state_nxt     = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout_q_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_last_owner_nxt = r_owner;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_grant_nxt = (w_state_nxt != S_IDLE);
    w_en_nxt    = (w_state_nxt == S_ACCESS) || (w_state_nxt == S_WAIT);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  // Registered outputs, so each one follows the state register in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_grant <= 1'b0;
      r_fetch_done  <= 1'b0;
      r_exec_grant  <= 1'b0;
      r_exec_done   <= 1'b0;
      r_mem_sel     <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_rw      <= 1'b1;
      r_bus_error   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_fetch_grant <= w_grant_nxt && (w_owner_nxt == OWN_FETCH);
      r_fetch_done  <= w_done_nxt  && (w_owner_nxt == OWN_FETCH);
      r_exec_grant  <= w_grant_nxt && (w_owner_nxt == OWN_EXEC);
      r_exec_done   <= w_done_nxt  && (w_owner_nxt == OWN_EXEC);
      r_mem_sel     <= w_grant_nxt && (w_owner_nxt == OWN_EXEC);
      r_mem_en      <= w_en_nxt;
      r_mem_rw      <= w_en_nxt ? w_rw_q_nxt : 1'b1;
      r_bus_error   <= w_done_nxt && w_timeout_q_nxt;
      r_busy        <= w_grant_nxt;
    end
  end

  assign fetch_grant = r_fetch_grant;
  assign fetch_done  = r_fetch_done;
  assign exec_grant  = r_exec_grant;
  assign exec_done   = r_exec_done;
  assign mem_sel     = r_mem_sel;
  assign MEM_EN      = r_mem_en;
  assign MEM_RW      = r_mem_rw;
  assign bus_error   = r_bus_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (default and 4-cycle watchdog) share stimulus.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic fetch_req, fetch_rw, exec_req, exec_rw, MFC;

  logic fg16, fd16, eg16, ed16, sel16, en16, rw16, be16, busy16;
  logic fg4, fd4, eg4, ed4, sel4, en4, rw4, be4, busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut16 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_rw(fetch_rw), .fetch_grant(fg16), .fetch_done(fd16),
    .exec_req(exec_req), .exec_rw(exec_rw), .exec_grant(eg16), .exec_done(ed16),
    .mem_sel(sel16), .MEM_EN(en16), .MEM_RW(rw16), .MFC(MFC),
    .bus_error(be16), .busy(busy16)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_rw(fetch_rw), .fetch_grant(fg4), .fetch_done(fd4),
    .exec_req(exec_req), .exec_rw(exec_rw), .exec_grant(eg4), .exec_done(ed4),
    .mem_sel(sel4), .MEM_EN(en4), .MEM_RW(rw4), .MFC(MFC),
    .bus_error(be4), .busy(busy4)
  );

  // Observation word: {fetch_grant, fetch_done, exec_grant, exec_done, mem_sel, MEM_EN, MEM_RW, bus_error, busy}
  logic [8:0] obs16, obs4;
  assign obs16 = {fg16, fd16, eg16, ed16, sel16, en16, rw16, be16, busy16};
  assign obs4  = {fg4,  fd4,  eg4,  ed4,  sel4,  en4,  rw4,  be4,  busy4};

  localparam logic [8:0] O_IDLE  = 9'b000000100;
  localparam logic [8:0] F_GRANT = 9'b100000101;
  localparam logic [8:0] F_MEM_R = 9'b100001101;
  localparam logic [8:0] F_DONE  = 9'b110000101;
  localparam logic [8:0] E_GRANT = 9'b001010101;
  localparam logic [8:0] E_MEM_R = 9'b001011101;
  localparam logic [8:0] E_MEM_W = 9'b001011001;
  localparam logic [8:0] E_DONE  = 9'b001110101;
  localparam logic [8:0] E_ERR   = 9'b001110111;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Leaves the bench at a negedge with reset released and all requests low (cycle 0 slot)
  task automatic do_reset();
    reset = 1'b1;
    fetch_req = 1'b0; fetch_rw = 1'b1; exec_req = 1'b0; exec_rw = 1'b1; MFC = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset16", obs16, O_IDLE);
    chk("reset4",  obs4,  O_IDLE);
    reset = 1'b0;
  endtask

  initial begin
    // 1: single fetch read, MFC on first WAIT
    do_reset();
    fetch_req = 1'b1; MFC = 1'b1;
    chk("t1_c0", obs16, O_IDLE);
    @(negedge clk); chk("t1_c1", obs16, F_GRANT);
    @(negedge clk); chk("t1_c2", obs16, F_MEM_R);
    @(negedge clk); chk("t1_c3", obs16, F_MEM_R);
    @(negedge clk); chk("t1_c4", obs16, F_DONE);
    fetch_req = 1'b0;
    @(negedge clk); chk("t1_c5", obs16, O_IDLE);

    // 2: both held, strict alternation starting with fetch
    do_reset();
    fetch_req = 1'b1; exec_req = 1'b1; MFC = 1'b1;
    @(negedge clk); chk("t2_c1", obs16, F_GRANT);
    repeat (3) @(negedge clk); chk("t2_c4", obs16, F_DONE);
    @(negedge clk); chk("t2_c5", obs16, O_IDLE);
    @(negedge clk); chk("t2_c6", obs16, E_GRANT);
    @(negedge clk); chk("t2_c7", obs16, E_MEM_R);
    repeat (2) @(negedge clk); chk("t2_c9", obs16, E_DONE);
    @(negedge clk); chk("t2_c10", obs16, O_IDLE);
    @(negedge clk); chk("t2_c11", obs16, F_GRANT);
    repeat (4) @(negedge clk); chk("t2_c15", obs16, O_IDLE);
    @(negedge clk); chk("t2_c16", obs16, E_GRANT);

    // 3: exec write, MFC on the 5th WAIT cycle
    do_reset();
    exec_req = 1'b1; exec_rw = 1'b0;
    @(negedge clk); chk("t3_c1", obs16, E_GRANT);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 7) MFC = 1'b1;
      chk($sformatf("t3_c%0d", c), obs16, E_MEM_W);
    end
    @(negedge clk); chk("t3_c8", obs16, E_DONE);
    exec_req = 1'b0; MFC = 1'b0;
    @(negedge clk); chk("t3_c9", obs16, O_IDLE);

    // 4a: MFC never arrives; 4-cycle and 16-cycle watchdogs, req dropped at done of the short one
    do_reset();
    exec_req = 1'b1; exec_rw = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1)      chk($sformatf("t4_w4_c%0d", c), obs4, E_GRANT);
      else if (c <= 6) chk($sformatf("t4_w4_c%0d", c), obs4, E_MEM_R);
      else if (c == 7) chk($sformatf("t4_w4_c%0d", c), obs4, E_ERR);
      else if (c <= 9) chk($sformatf("t4_w4_c%0d", c), obs4, O_IDLE);
      if (c == 7) exec_req = 1'b0;
      if (c == 1)       chk($sformatf("t4_w16_c%0d", c), obs16, E_GRANT);
      else if (c <= 18) begin
        if (c == 2 || c == 18) chk($sformatf("t4_w16_c%0d", c), obs16, E_MEM_R);
      end
      else if (c == 19) chk($sformatf("t4_w16_c%0d", c), obs16, E_ERR);
      else              chk($sformatf("t4_w16_c%0d", c), obs16, O_IDLE);
    end

    // 4b: MFC on the last allowed WAIT cycle counts as success
    do_reset();
    exec_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4b_c6", obs4, E_MEM_R);
    MFC = 1'b1;
    @(negedge clk); chk("t4b_c7", obs4, E_DONE);
    exec_req = 1'b0; MFC = 1'b0;
    @(negedge clk); chk("t4b_c8", obs4, O_IDLE);

    // 5a: fetch drops in GRANT; turn order unchanged so fetch still wins the next tie
    do_reset();
    fetch_req = 1'b1; MFC = 1'b1;
    @(negedge clk); chk("t5a_c1", obs16, F_GRANT);
    fetch_req = 1'b0;
    @(negedge clk); chk("t5a_c2", obs16, O_IDLE);
    fetch_req = 1'b1; exec_req = 1'b1;
    @(negedge clk); chk("t5a_c3", obs16, F_GRANT);
    fetch_req = 1'b0; exec_req = 1'b0;
    @(negedge clk); chk("t5a_c4", obs16, O_IDLE);

    // 5b: fetch drops during WAIT; access still completes
    do_reset();
    fetch_req = 1'b1;
    repeat (3) @(negedge clk); chk("t5b_c3", obs16, F_MEM_R);
    fetch_req = 1'b0;
    @(negedge clk); chk("t5b_c4", obs16, F_MEM_R);
    MFC = 1'b1;
    @(negedge clk); chk("t5b_c5", obs16, F_DONE);
    @(negedge clk); chk("t5b_c6", obs16, O_IDLE);

    // 6: async reset mid-WAIT, then fetch wins after release
    do_reset();
    exec_req = 1'b1; exec_rw = 1'b0;
    repeat (4) @(negedge clk); chk("t6_wait", obs16, E_MEM_W);
    reset = 1'b1;
    #1 chk("t6_async16", obs16, O_IDLE);
    chk("t6_async4", obs4, O_IDLE);
    fetch_req = 1'b1;
    @(negedge clk); chk("t6_held", obs16, O_IDLE);
    reset = 1'b0;
    @(negedge clk); chk("t6_c1", obs16, F_GRANT);
    fetch_req = 1'b0; exec_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
